// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator
// BCD credit accumulator for the vending machine datapath. Coins are added to a
// DIGITS-wide BCD credit, a vend deducts the item price one unit per cycle, and a
// refund pays the whole credit back out as unit change pulses.
// Build option: define COIN_FAST_ADD_EN to add a whole coin in one cycle through
// a saturating BCD adder instead of stepping one unit per cycle.
module coin_credit_accumulator #(
    parameter int DIGITS = 2,
    parameter int VAL_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                coin_valid,
    input  logic [VAL_W-1:0]    coin_val,
    output logic                coin_ready,
    input  logic                vend_req,
    input  logic [4*DIGITS-1:0] price,
    output logic                vend_done,
    output logic                vend_deny,
    input  logic                refund_req,
    output logic                change_pulse,
    output logic                refund_done,
    output logic [4*DIGITS-1:0] credit_bcd,
    output logic                sat_flag,
    output logic                busy
);

    localparam int            CW   = 4 * DIGITS;
    localparam logic [CW-1:0] ALL9 = {DIGITS{4'h9}};

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_VEND, S_CHANGE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_credit;
    logic [CW-1:0]      r_remain;
    logic [VAL_W-1:0]   r_units;
    logic               r_sat;
    logic               r_vend_deny;

    logic               w_idle_go;
    logic               w_take_refund;
    logic               w_take_vend;
    logic               w_take_coin;
    logic               w_price_ok;

    // Add one to a BCD value; a 9 rolls to 0 and carries into the next digit.
    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Subtract one from a BCD value; a 0 rolls to 9 and borrows from the next digit.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [CW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

`ifdef COIN_FAST_ADD_EN
    logic [CW-1:0] w_fast_sum;
    logic          w_fast_ovf;

    // Returns {overflow, sum}; the sum clamps to all 9s on overflow.
    function automatic logic [CW:0] bcd_add_sat(input logic [CW-1:0] v,
                                                input logic [VAL_W-1:0] a);
        logic [CW-1:0]    r;
        logic [VAL_W+4:0] s;
        logic [VAL_W+4:0] c;
        r = v;
        c = (VAL_W+5)'(a);
        for (int i = 0; i < DIGITS; i++) begin
            s           = (VAL_W+5)'(v[4*i +: 4]) + c;
            r[4*i +: 4] = 4'(s % (VAL_W+5)'(10));
            c           = s / (VAL_W+5)'(10);
        end
        if (c != '0) return {1'b1, ALL9};
        return {1'b0, r};
    endfunction

    assign {w_fast_ovf, w_fast_sum} = bcd_add_sat(r_credit, r_units);
`endif

    // With every digit valid, BCD order equals plain unsigned order of the packed
    // nibbles, so the magnitude compare needs no per-digit logic.
    assign w_price_ok    = bcd_valid(price) && (r_credit >= price);

    // Only one request is taken per edge: refund beats vend beats coin.
    assign w_idle_go     = enable && (r_state == S_IDLE);
    assign w_take_refund = w_idle_go && refund_req;
    assign w_take_vend   = w_idle_go && !refund_req && vend_req;
    assign w_take_coin   = w_idle_go && !refund_req && !vend_req && coin_valid;

    assign credit_bcd    = r_credit;
    assign sat_flag      = r_sat;
    assign busy          = (r_state != S_IDLE);
    assign vend_deny     = r_vend_deny && enable;

    // State register; enable=0 freezes the FSM.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (reset)       r_state <= S_IDLE;
        else if (enable) r_state <= w_next;
    end

    // Next-state decode and the cycle-level pulse outputs.
    always_comb begin
        // NOTE: every output is defaulted first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        w_next       = r_state;
        coin_ready   = 1'b0;
        vend_done    = 1'b0;
        refund_done  = 1'b0;
        change_pulse = 1'b0;
        if (enable) begin
            case (r_state)
                S_IDLE: begin
                    coin_ready = 1'b1;
                    if (w_take_refund)                  w_next = S_CHANGE;
                    else if (w_take_vend && w_price_ok) w_next = S_VEND;
                    else if (w_take_coin)               w_next = S_ADD;
                end
`ifdef COIN_FAST_ADD_EN
                S_ADD: w_next = S_IDLE;
`else
                S_ADD: if (r_units <= VAL_W'(1)) w_next = S_IDLE;
`endif
                S_VEND: begin
                    if (r_remain == '0) begin
                        vend_done = 1'b1;
                        w_next    = S_IDLE;
                    end
                end
                S_CHANGE: begin
                    if (r_credit == '0) begin
                        refund_done = 1'b1;
                        w_next      = S_IDLE;
                    end else begin
                        change_pulse = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Credit, remaining price, unit counter, saturation flag and deny pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credit    <= '0;
            r_remain    <= '0;
            r_units     <= '0;
            r_sat       <= 1'b0;
            r_vend_deny <= 1'b0;
        end else if (enable) begin
            r_vend_deny <= w_take_vend && !w_price_ok;
            case (r_state)
                S_IDLE: begin
                    if (w_take_vend && w_price_ok) r_remain <= price;
                    if (w_take_coin)               r_units  <= coin_val;
                end
                S_ADD: begin
`ifdef COIN_FAST_ADD_EN
                    r_credit <= w_fast_sum;
                    if (w_fast_ovf) r_sat <= 1'b1;
`else
                    if (r_units != '0) begin
                        r_units <= r_units - 1'b1;
                        // At all 9s the unit is dropped rather than wrapping.
                        if (r_credit == ALL9) r_sat    <= 1'b1;
                        else                  r_credit <= bcd_inc(r_credit);
                    end
`endif
                end
                S_VEND: begin
                    if (r_remain != '0) begin
                        r_remain <= bcd_dec(r_remain);
                        r_credit <= bcd_dec(r_credit);
                    end
                end
                S_CHANGE: begin
                    if (r_credit != '0) r_credit <= bcd_dec(r_credit);
                    else                r_sat    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Self-checking bench for coin_credit_accumulator (DIGITS=2, VAL_W=4).
// Reference model tracks credit as a plain integer 0..99 plus a sticky overflow bit.
module tb_coin_credit_accumulator;

    localparam int LIMIT = 300;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       coin_valid;
    logic [3:0] coin_val;
    logic       coin_ready;
    logic       vend_req;
    logic [7:0] price;
    logic       vend_done;
    logic       vend_deny;
    logic       refund_req;
    logic       change_pulse;
    logic       refund_done;
    logic [7:0] credit_bcd;
    logic       sat_flag;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;
    int m_credit = 0;
    bit m_sat    = 1'b0;

    coin_credit_accumulator #(.DIGITS(2), .VAL_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .coin_ready   (coin_ready),
        .vend_req     (vend_req),
        .price        (price),
        .vend_done    (vend_done),
        .vend_deny    (vend_deny),
        .refund_req   (refund_req),
        .change_pulse (change_pulse),
        .refund_done  (refund_done),
        .credit_bcd   (credit_bcd),
        .sat_flag     (sat_flag),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int cap99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    task automatic do_coin(input logic [3:0] v);
        int start;
        int k;
        int exp_k;
        start = m_credit;
        check("coin_ready_idle", coin_ready, 1);
        coin_valid = 1'b1;
        coin_val   = v;
        step();
        coin_valid = 1'b0;
        coin_val   = 4'd0;
        k = 0;
        while (busy && k < LIMIT) begin
            check("add_step_credit", credit_bcd, to_bcd(cap99(start + k)));
            k++;
            step();
        end
`ifdef COIN_FAST_ADD_EN
        exp_k = 1;
`else
        exp_k = (v == 0) ? 1 : int'(v);
`endif
        check("add_busy_cycles", k, exp_k);
        if (start + int'(v) > 99) m_sat = 1'b1;
        m_credit = cap99(start + int'(v));
        check("add_credit", credit_bcd, to_bcd(m_credit));
        check("add_sat", sat_flag, m_sat);
    endtask

    task automatic do_vend(input logic [7:0] p);
        bit valid;
        int pv;
        int k;
        int dones;
        int done_at;
        valid = (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9);
        pv    = int'(p[7:4]) * 10 + int'(p[3:0]);
        vend_req = 1'b1;
        price    = p;
        step();
        vend_req = 1'b0;
        if (valid && m_credit >= pv) begin
            k = 0;
            dones = 0;
            done_at = -1;
            while (busy && k < LIMIT) begin
                if (vend_done) begin
                    dones++;
                    done_at = k;
                end
                k++;
                step();
            end
            check("vend_busy_cycles", k, pv + 1);
            check("vend_done_count", dones, 1);
            check("vend_done_cycle", done_at, pv);
            m_credit = m_credit - pv;
        end else begin
            check("deny_pulse", vend_deny, 1);
            check("deny_stays_idle", busy, 0);
            step();
            check("deny_single_cycle", vend_deny, 0);
        end
        check("vend_credit", credit_bcd, to_bcd(m_credit));
    endtask

    task automatic do_refund(input bit with_others);
        int exp_n;
        int k;
        int pulses;
        int dones;
        bit ready_seen;
        exp_n = m_credit;
        refund_req = 1'b1;
        if (with_others) begin
            vend_req   = 1'b1;
            price      = 8'h01;
            coin_valid = 1'b1;
            coin_val   = 4'd3;
        end
        step();
        refund_req = 1'b0;
        vend_req   = 1'b0;
        coin_valid = 1'b0;
        coin_val   = 4'd0;
        k = 0;
        pulses = 0;
        dones = 0;
        ready_seen = 1'b0;
        while (busy && k < LIMIT) begin
            if (change_pulse) pulses++;
            if (refund_done)  dones++;
            if (coin_ready)   ready_seen = 1'b1;
            k++;
            step();
        end
        check("refund_busy_cycles", k, exp_n + 1);
        check("refund_pulses", pulses, exp_n);
        check("refund_done_count", dones, 1);
        check("refund_no_coin_ready", ready_seen, 0);
        m_credit = 0;
        m_sat    = 1'b0;
        check("refund_credit", credit_bcd, 8'h00);
        check("refund_sat_clear", sat_flag, 0);
    endtask

    initial begin
        int lim;
        int op;
        logic [7:0] p;

        reset      = 1'b1;
        enable     = 1'b1;
        coin_valid = 1'b0;
        coin_val   = 4'd0;
        vend_req   = 1'b0;
        price      = 8'h00;
        refund_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        check("rst_credit", credit_bcd, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_pulses", {vend_done, vend_deny, change_pulse, refund_done}, 4'b0000);
        check("rst_coin_ready", coin_ready, 1);

        // Coins 5, 7, 9: carries 09->10 and 19->20 checked cycle by cycle.
        do_coin(4'd5);
        do_coin(4'd7);
        do_coin(4'd9);
        check("sum_21", credit_bcd, 8'h21);

        do_vend(8'h15);
        check("after_vend_06", credit_bcd, 8'h06);
        do_vend(8'h07);

        // Refund, vend and coin requested together: refund must win.
        do_refund(1'b1);

        // Build 95, then overflow with a 9.
        for (int i = 0; i < 10; i++) do_coin(4'd9);
        do_coin(4'd5);
        check("credit_95", credit_bcd, 8'h95);
        do_coin(4'd9);
        check("sat_99", credit_bcd, 8'h99);
        check("sat_flag_set", sat_flag, 1);
        do_refund(1'b0);

        // Credit 50 with an invalid BCD price, then a zero price.
        for (int i = 0; i < 5; i++) do_coin(4'd9);
        do_coin(4'd5);
        do_vend(8'h1A);
        do_vend(8'h00);
        check("zero_price_credit", credit_bcd, 8'h50);
        do_refund(1'b0);
        do_refund(1'b0);

        // enable=0 blocks coin_ready even in IDLE.
        enable = 1'b0;
        #1;
        check("en_low_ready", coin_ready, 0);
        enable = 1'b1;
        #1;

        // Freeze an ADD of 8 with enable low for 4 cycles.
        coin_valid = 1'b1;
        coin_val   = 4'd8;
        step();
        coin_valid = 1'b0;
        coin_val   = 4'd0;
`ifndef COIN_FAST_ADD_EN
        step();
        step();
        step();
        check("freeze_pre", credit_bcd, 8'h03);
`endif
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef COIN_FAST_ADD_EN
            check("freeze_credit", credit_bcd, 8'h00);
`else
            check("freeze_credit", credit_bcd, 8'h03);
`endif
            check("freeze_busy", busy, 1);
            check("freeze_ready", coin_ready, 0);
        end
        enable = 1'b1;
        begin
            int k;
            k = 0;
            while (busy && k < LIMIT) begin
                k++;
                step();
            end
`ifdef COIN_FAST_ADD_EN
            check("resume_cycles", k, 1);
`else
            check("resume_cycles", k, 5);
`endif
        end
        m_credit = 8;
        check("resume_credit", credit_bcd, 8'h08);

        // Reset in the middle of a vend of 5.
        vend_req = 1'b1;
        price    = 8'h05;
        step();
        vend_req = 1'b0;
        step();
        step();
        check("midvend_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_credit", credit_bcd, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_pulses", {vend_done, vend_deny, change_pulse, refund_done}, 4'b0000);
        step();
        reset = 1'b0;
        m_credit = 0;
        m_sat    = 1'b0;
        step();
        check("post_abort_credit", credit_bcd, 8'h00);
        check("post_abort_pulses", {vend_done, change_pulse, busy}, 3'b000);

        // Random transactions against the integer model.
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 9));
            if (op < 5) begin
                do_coin(4'($urandom_range(0, 15)));
            end else if (op < 8) begin
                if ($urandom_range(0, 4) == 0) begin
                    p = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 9))};
                end else begin
                    lim = cap99(m_credit + 5);
                    p = to_bcd(int'($urandom_range(0, lim)));
                end
                do_vend(p);
            end else begin
                do_refund(1'b0);
            end
            repeat ($urandom_range(0, 2)) step();
        end
        check("final_credit", credit_bcd, to_bcd(m_credit));
        check("final_sat", sat_flag, m_sat);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_credit_accumulator.md
Name: coin_credit_accumulator

Overview:
- Parametrised successor to the single-digit money counter in the vending machine datapath.
- Accumulates inserted-coin credit as a DIGITS-wide BCD value.
- Deducts an item price on a vend request and pays out remaining credit as unit change pulses on refund.
- Sits between the coin-acceptor/keypad front end and the display/vend FSM; synchronous enable replaces the old clock gating.

Parameters:
- DIGITS, 2, number of BCD credit digits; max credit is 10^DIGITS-1.
- VAL_W, 4, width of the binary coin value input (units per coin).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  synchronous advance enable; low freezes all state.
- coin_valid  in  1  coin present; accepted when coin_ready is also high.
- coin_val  in  VAL_W  coin value in units, binary.
- coin_ready  out  1  high in IDLE while enable=1.
- vend_req  in  1  level request; sampled only in IDLE.
- price  in  4*DIGITS  BCD price; must be held stable from acceptance until vend_done.
- vend_done  out  1  one-cycle pulse when the price deduction completes.
- vend_deny  out  1  one-cycle pulse when credit < price or price is invalid BCD.
- refund_req  in  1  request to return all credit as change.
- change_pulse  out  1  high for each cycle in which one unit is refunded.
- refund_done  out  1  one-cycle pulse when credit reaches 0 in CHANGE.
- credit_bcd  out  4*DIGITS  current credit, BCD.
- sat_flag  out  1  sticky: credit saturated and coin units were discarded.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - State IDLE.
  - credit_bcd=0; internal remaining-price register=0.
  - All pulse outputs 0; sat_flag=0.
- enable=0:
  - Holds state, credit, counters and sat_flag.
  - Forces coin_ready=0, vend_done/vend_deny/refund_done=0, change_pulse=0.
- FSM states: IDLE, ADD, VEND, CHANGE.
- IDLE priority when enable=1: refund_req > vend_req > coin_valid. Only one request is accepted per edge.
- Coin accept (edge T):
  - Latch coin_val into the unit counter and go to ADD.
  - Edges T+1..T+N each add 1 to credit (BCD ripple: digit 9 -> 0 with carry into the next digit).
  - Transition to IDLE on edge T+N.
  - coin_val=0: return to IDLE at T+1 with no change.
- Saturation: an increment at credit = all 9s does not wrap. Credit holds, sat_flag sets, and remaining units are dropped; ADD still ends after N cycles.
- Vend accept (edge T): BCD magnitude compare of credit against price.
  - credit >= price and price valid: load remaining=price and go to VEND. Each cycle decrement credit and remaining by 1 (BCD borrow: 0 -> 9). When remaining reaches 0, pulse vend_done and go to IDLE.
  - price=0: vend_done at T+1, credit unchanged.
  - credit < price, or any price digit > 9: vend_deny pulses at T+1, state stays IDLE, credit unchanged.
- Refund accept (edge T): go to CHANGE.
  - Each cycle with credit != 0: decrement credit by 1 with change_pulse=1.
  - When credit is 0: pulse refund_done, clear sat_flag, go to IDLE.
  - credit=0 at accept: refund_done at T+1 and zero change pulses.
- Requests arriving while busy are ignored, not queued; requesters must hold or retry.
- Reset mid-operation aborts immediately to reset values. No change pulses are emitted after reset assertion.
- credit_bcd is always a registered, valid BCD value.

Optional Feature:
- Macro: COIN_FAST_ADD_EN.
- Defined:
  - ADD lasts exactly one cycle: the whole coin_val is added through a saturating BCD adder.
  - Credit is updated at T+1 and the FSM returns to IDLE at T+1.
  - Overflow clamps credit to all 9s and sets sat_flag.
- Undefined: unit-step ADD as described above.
- All other behaviour is identical in both builds.

Test Plan (DIGITS=2, VAL_W=4):
- Reset, then coins 5, 7, 9 -> credit_bcd=0x21. busy high for 5, 7 and 9 cycles respectively. Verify the 09->10 and 19->20 carries.
- Credit 0x21, price=0x15, vend_req -> 15 decrement cycles, vend_done pulse, credit=0x06. Then price=0x07 -> vend_deny at T+1, credit still 0x06.
- Credit 0x95, coin 9 -> credit stops at 0x99 and sat_flag=1. refund_req -> exactly 99 change_pulse cycles, refund_done, credit=0x00, sat_flag=0.
- In IDLE, assert refund_req, vend_req and coin_valid on the same edge -> refund wins; coin_ready=0 during CHANGE; the coin is not counted.
- Coin 8 accepted, drop enable for 4 cycles after 3 increments -> credit frozen at 0x03, then resumes to 0x08. Assert reset mid-VEND -> credit=0, IDLE, no pulses.
- price=0x1A (invalid BCD) with credit 0x50 -> vend_deny. With COIN_FAST_ADD_EN, coin 9 on credit 0x95 -> credit=0x99 and sat_flag=1 at T+1.
